// File: rtl/mmio_display_port.sv
// Bus-mapped 8-digit seven-segment display port: VALUE/STATUS/CTRL registers,
// a 32-cycle double-dabble converter and a registered digit scanner.
module mmio_display_port #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0100,
  parameter int          SCAN_DIV  = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic [1:0]  store_size,
  input  logic [31:0] endereco,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        sel,
  output logic [6:0]  seg,
  output logic [7:0]  an,
  output logic        busy
);
  localparam int NUM_DIGITS = 8;
  localparam int BCD_DIGITS = 10;
  localparam int DIV_W      = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_TERM = DIV_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t                         state_q;
  logic [31:0]                    value_q, bin_q, merged;
  logic [2:0]                     ctrl_q;
  logic [4:0]                     cnt_q;
  logic [BCD_DIGITS*4-1:0]        bcd_q, bcd_adj;
  logic [NUM_DIGITS-1:0][3:0]     digits_q;
  logic                           ovf_q, blank_q;
  logic [DIV_W-1:0]               div_q;
  logic [2:0]                     idx_q;
  logic [1:0]                     offs;
  logic                           store_ok, wr_value, wr_ctrl;
  logic [NUM_DIGITS-1:0]          lz;
  logic [6:0]                     seg_next;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'h0: seg7 = 7'b1000000;  4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;  4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;  4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;  4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;  4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;  4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;  4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;  default: seg7 = 7'b0001110;
    endcase
  endfunction

  assign sel  = (endereco[31:4] == BASE_ADDR[31:4]);
  assign offs = endereco[3:2];

  // Byte-lane merge of a store into VALUE; misaligned half/word stores are dropped.
  always_comb begin
    merged   = value_q;
    store_ok = 1'b0;
    case (store_size)
      2'b00: begin
        store_ok = 1'b1;
        merged[{endereco[1:0], 3'b000} +: 8] = write_data[7:0];
      end
      2'b01: if (!endereco[0]) begin
        store_ok = 1'b1;
        merged[{endereco[1], 4'b0000} +: 16] = write_data[15:0];
      end
      default: if (endereco[1:0] == 2'b00) begin
        store_ok = 1'b1;
        merged   = write_data;
      end
    endcase
  end

  assign wr_value = mem_write && sel && (offs == 2'd0) && store_ok;
  assign wr_ctrl  = mem_write && sel && (offs == 2'd2);

  always_comb begin
    read_data = 32'd0;
    if (mem_read && sel) begin
      case (offs)
        2'd0:    read_data = value_q;
        2'd1:    read_data = {30'd0, ovf_q, busy};
        2'd2:    read_data = {29'd0, ctrl_q};
        default: read_data = 32'd0;
      endcase
    end
  end

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
    assign bcd_adj[g*4 +: 4] = (bcd_q[g*4 +: 4] >= 4'd5) ? bcd_q[g*4 +: 4] + 4'd3
                                                        : bcd_q[g*4 +: 4];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      value_q  <= 32'd0;
      ctrl_q   <= 3'b001;
      bin_q    <= 32'd0;
      bcd_q    <= '0;
      cnt_q    <= 5'd0;
      digits_q <= '0;
      ovf_q    <= 1'b0;
      blank_q  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl_q <= write_data[2:0];
      if (wr_value) begin
        // A store while busy simply restarts from the merged value.
        value_q <= merged;
        bin_q   <= merged;
        bcd_q   <= '0;
        cnt_q   <= 5'd0;
        state_q <= S_SHIFT;
        busy    <= 1'b1;
      end else begin
        case (state_q)
          S_SHIFT: begin
            bcd_q <= {bcd_adj[BCD_DIGITS*4-2:0], bin_q[31]};
            bin_q <= {bin_q[30:0], 1'b0};
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) state_q <= S_DONE;
          end
          S_DONE: begin
            if (ctrl_q[1]) begin
              digits_q <= value_q;
              ovf_q    <= 1'b0;
            end else begin
              digits_q <= bcd_q[31:0];
              ovf_q    <= |bcd_q[39:32];
            end
            blank_q <= ctrl_q[2];
            state_q <= S_IDLE;
            busy    <= 1'b0;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // lz[i]: digit i and every digit above it are zero.
  always_comb begin
    lz = '0;
    lz[NUM_DIGITS-1] = (digits_q[NUM_DIGITS-1] == 4'd0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--)
      lz[i] = lz[i+1] && (digits_q[i] == 4'd0);
    if (ovf_q)                                      seg_next = 7'b0111111;
    else if (blank_q && (idx_q != 3'd0) && lz[idx_q]) seg_next = 7'h7F;
    else                                            seg_next = seg7(digits_q[idx_q]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
      idx_q <= 3'd0;
      an    <= 8'hFE;
      seg   <= 7'b1000000;
    end else begin
      seg <= seg_next;
      if (ctrl_q[0]) begin
        an <= ~(8'd1 << idx_q);
        if (div_q == DIV_TERM) begin
          div_q <= '0;
          idx_q <= idx_q + 3'd1;
        end else begin
          div_q <= div_q + 1'b1;
        end
      end else begin
        div_q <= '0;
        an    <= 8'hFF;
      end
    end
  end
endmodule

// File: tb/tb_mmio_display_port.sv
// Directed + randomized bench for mmio_display_port against an arithmetic
// model of the register window and the displayed digits.
module tb_mmio_display_port;
  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam int          SD   = 4;

  logic        clk = 1'b0, reset = 1'b1;
  logic        mem_write = 1'b0, mem_read = 1'b0;
  logic [1:0]  store_size = 2'b10;
  logic [31:0] endereco = 32'd0, write_data = 32'd0;
  logic [31:0] read_data;
  logic        sel, busy;
  logic [6:0]  seg;
  logic [7:0]  an;

  int checks = 0, failures = 0;

  // Model state: register contents and what is currently committed to the display.
  logic [31:0] m_value = 32'd0;
  logic [2:0]  m_ctrl  = 3'b001;
  logic [31:0] d_val   = 32'd0;
  logic        d_hex   = 1'b0, d_blank = 1'b0;

  mmio_display_port #(.BASE_ADDR(BASE), .SCAN_DIV(SD)) dut (
    .clk(clk), .reset(reset), .mem_write(mem_write), .mem_read(mem_read),
    .store_size(store_size), .endereco(endereco), .write_data(write_data),
    .read_data(read_data), .sel(sel), .seg(seg), .an(an), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] font(input int n);
    logic [6:0] t [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return t[n];
  endfunction

  function automatic logic model_ovf();
    return !d_hex && (d_val > 32'd99_999_999);
  endfunction

  function automatic logic [6:0] exp_seg(input int i);
    longint unsigned p = 1;
    longint unsigned v = longint'(d_val);
    longint unsigned upper;
    int dig;
    if (model_ovf()) return 7'b0111111;
    for (int k = 0; k < i; k++) p = p * 10;
    if (d_hex) begin
      upper = v >> (4 * i);
      dig   = int'(upper % 16);
    end else begin
      upper = v / p;
      dig   = int'(upper % 10);
    end
    if (d_blank && i > 0 && upper == 0) return 7'h7F;
    return font(dig);
  endfunction

  // Applies the store to the model; returns 1 when a conversion is started.
  function automatic bit model_store(input logic [31:0] a, input logic [31:0] d,
                                     input logic [1:0] sz);
    int lane = int'(a[1:0]);
    logic [31:0] mask;
    if (a[31:4] != BASE[31:4]) return 0;
    if (a[3:2] == 2'd2) begin m_ctrl = d[2:0]; return 0; end
    if (a[3:2] != 2'd0) return 0;
    if (sz == 2'b00)                    mask = 32'hFF << (8 * lane);
    else if (sz == 2'b01 && lane % 2 == 0) mask = 32'hFFFF << (8 * lane);
    else if (sz[1] && lane == 0)        mask = 32'hFFFF_FFFF;
    else return 0;
    m_value = (m_value & ~mask) | ((d << (8 * lane)) & mask);
    return 1;
  endfunction

  task automatic model_commit();
    d_val = m_value; d_hex = m_ctrl[1]; d_blank = m_ctrl[2];
  endtask

  // Drives one store cycle; returns on the falling edge after the accepting edge.
  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                       output bit started);
    @(negedge clk);
    endereco = a; write_data = d; store_size = sz; mem_write = 1'b1; mem_read = 1'b0;
    started = model_store(a, d, sz);
    @(negedge clk);
    mem_write = 1'b0;
  endtask

  task automatic rd(input int offs, output logic [31:0] d);
    @(negedge clk);
    endereco = BASE + 32'(offs * 4); mem_read = 1'b1;
    #1 d = read_data;
    mem_read = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk({tag, "_timeout"}, {31'd0, busy}, 32'd0);
    model_commit();
  endtask

  // Word store to VALUE with per-cycle busy/STATUS timing checks through the commit.
  task automatic timed_store(input string tag, input logic [31:0] d);
    bit st;
    logic old_ovf, new_ovf;
    old_ovf = model_ovf();
    store(BASE, d, 2'b10, st);
    new_ovf = !m_ctrl[1] && (m_value > 32'd99_999_999);
    for (int k = 0; k <= 33; k++) begin
      if (k > 0) @(negedge clk);
      endereco = BASE + 32'd4; mem_read = 1'b1;
      #1;
      chk({tag, "_busy"}, {31'd0, busy}, {31'd0, (k <= 32)});
      chk({tag, "_status"}, read_data, {30'd0, (k <= 32) ? old_ovf : new_ovf, (k <= 32)});
    end
    mem_read = 1'b0;
    model_commit();
  endtask

  task automatic check_display(input string tag);
    logic [7:0] seen = 8'h00;
    int idx;
    repeat (2) @(negedge clk);
    for (int c = 0; c < 8 * SD + 4; c++) begin
      @(negedge clk);
      idx = 0;
      for (int i = 7; i >= 0; i--) if (an[i] == 1'b0) idx = i;
      chk({tag, "_an"}, {24'd0, an}, {24'd0, ~(8'd1 << idx)});
      chk($sformatf("%s_seg%0d", tag, idx), {25'd0, seg}, {25'd0, exp_seg(idx)});
      seen[idx] = 1'b1;
    end
    chk({tag, "_scan_all"}, {24'd0, seen}, 32'hFF);
  endtask

  initial begin
    logic [31:0] d;
    bit st;
    int r;

    // Reset held 20 cycles.
    repeat (20) @(negedge clk);
    chk("rst_an", {24'd0, an}, 32'hFE);
    chk("rst_seg", {25'd0, seg}, 32'h40);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    rd(2, d); chk("rst_ctrl", d, 32'h1);
    rd(1, d); chk("rst_status", d, 32'h0);
    rd(0, d); chk("rst_value", d, 32'h0);
    endereco = BASE + 32'd8; mem_read = 1'b0;
    #1 chk("rd_gate", read_data, 32'd0);
    endereco = 32'h0000_0200;
    #1 chk("sel_off", {31'd0, sel}, 32'd0);
    check_display("rst_disp");

    timed_store("dec", 32'd12345678);
    check_display("dec_disp");

    timed_store("ovf", 32'd100_000_000);
    check_display("ovf_disp");

    // Mode change must not touch the display until the next commit.
    store(BASE + 32'd8, 32'hFFFF_FFF7, 2'b10, st);
    rd(2, d); chk("ctrl_rd", d, 32'h7);
    check_display("lazy_mode");
    timed_store("hex", 32'h00DE_00AD);
    check_display("hex_disp");

    store(BASE + 32'd8, 32'h1, 2'b00, st);
    timed_store("base", 32'h1122_3344);
    store(BASE + 32'd1, 32'h0000_0055, 2'b00, st);
    wait_idle("byte");
    rd(0, d); chk("byte_merge", d, m_value);
    chk("byte_exact", d, 32'h1122_5544);
    store(BASE + 32'd1, 32'h0000_9999, 2'b01, st);
    @(negedge clk); chk("half_mis_busy", {31'd0, busy}, 32'd0);
    rd(0, d); chk("half_mis", d, 32'h1122_5544);
    store(BASE + 32'd2, 32'h0000_BEEF, 2'b01, st);
    wait_idle("half");
    rd(0, d); chk("half_merge", d, 32'hBEEF_5544);
    store(BASE + 32'd12, 32'h1234, 2'b10, st);
    rd(3, d); chk("reg3", d, 32'd0);

    // Simultaneous write and read shows the pre-write value.
    @(negedge clk);
    endereco = BASE; write_data = 32'd777; store_size = 2'b10;
    mem_write = 1'b1; mem_read = 1'b1;
    #1 chk("wr_rd_old", read_data, m_value);
    st = model_store(BASE, 32'd777, 2'b10);
    @(negedge clk); mem_write = 1'b0; mem_read = 1'b0;
    rd(0, d); chk("wr_rd_new", d, 32'd777);
    wait_idle("wrrd");
    check_display("wrrd_disp");

    // Restart: only the second value commits, 33 cycles after it.
    store(BASE, 32'd5, 2'b10, st);
    repeat (9) @(negedge clk);
    timed_store("restart", 32'd9);
    check_display("restart_disp");

    for (int it = 0; it < 12; it++) begin
      store(BASE + 32'd8, {29'd0, 2'($urandom_range(0, 3)), 1'b1}, 2'b10, st);
      r = int'($urandom_range(0, 3));
      if (r == 0)      d = $urandom;
      else if (r == 1) d = $urandom_range(0, 99_999_999);
      else if (r == 2) d = $urandom_range(0, 999);
      else             d = 32'd99_999_999 + 32'($urandom_range(0, 2));
      timed_store($sformatf("rnd%0d", it), d);
      check_display($sformatf("rnd%0d", it));
      store(BASE + 32'($urandom_range(0, 3)), $urandom, 2'($urandom_range(0, 2)), st);
      wait_idle("rnd_sub");
      rd(0, d); chk("rnd_value", d, m_value);
    end

    store(BASE + 32'd8, 32'h0, 2'b10, st);
    repeat (2) @(negedge clk);
    for (int c = 0; c < 3 * SD; c++) begin
      @(negedge clk); chk("disabled_an", {24'd0, an}, 32'hFF);
    end

    // Reset mid-conversion: no commit, everything back to reset state.
    store(BASE + 32'd8, 32'h1, 2'b10, st);
    store(BASE, 32'd87654321, 2'b10, st);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_an", {24'd0, an}, 32'hFE);
    chk("mid_rst_seg", {25'd0, seg}, 32'h40);
    reset = 1'b0;
    m_value = 32'd0; m_ctrl = 3'b001;
    d_val = 32'd0; d_hex = 1'b0; d_blank = 1'b0;
    rd(0, d); chk("mid_rst_value", d, 32'd0);
    repeat (40) @(negedge clk);
    chk("mid_rst_nocommit_busy", {31'd0, busy}, 32'd0);
    check_display("mid_rst_disp");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mmio_display_port.md
# mmio_display_port

Memory-mapped responder peripheral for the processor's data-memory bus: it accepts the datapath's load/store transactions in a small register window and drives an 8-digit, time-multiplexed seven-segment display. A stored 32-bit result is converted to decimal BCD by a sequential double-dabble engine (32 cycles) and shown atomically once conversion completes. The block sits beside the data memory, decoded by address, and replaces direct display taps of RAM words.

## Interface
- BASE_ADDR, 32'h0000_0100, byte address of the register window (16-byte aligned).
- SCAN_DIV, 50000, clock cycles each digit stays lit; minimum 2.
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_write  in  1  store strobe from datapath.
- mem_read  in  1  load strobe from datapath.
- store_size  in  2  00 byte, 01 half, 10 word (11 treated as word).
- endereco  in  32  byte address.
- write_data  in  32  store data, right-aligned.
- read_data  out  32  load data, combinational, 0 when not selected.
- sel  out  1  combinational: endereco[31:4] == BASE_ADDR[31:4]; used by the memory mux.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- an  out  8  digit enables, active-low, an[0] = rightmost digit.
- busy  out  1  conversion in progress.

## Operation
- Registers (offset = endereco[3:2]):
  - 0 VALUE: RW, 32-bit.
  - 1 STATUS: RO; bit0 busy, bit1 overflow (last converted value > 99_999_999).
  - 2 CTRL: RW bits[2:0]; bit0 enable, bit1 hex mode, bit2 leading-zero blanking. Other bits read 0.
  - 3: reads 0, writes ignored.
- Stores to VALUE merge per store_size at byte lane endereco[1:0]:
  - byte: any lane.
  - half: lane endereco[1] × 2.
  - word: all lanes.
  - Misaligned half/word stores are ignored.
- CTRL takes write_data[2:0] on any store size.
- Any VALUE store starts a new conversion; a store while busy aborts and restarts with the merged value.
- Conversion FSM: IDLE → SHIFT (32 iterations: add 3 to each BCD nibble ≥ 5, then shift left 1, feeding the MSB of the shift register) → DONE (1 cycle: commit) → IDLE.
  - Decimal mode commit: digits[7:0] = low 8 BCD digits; overflow = any of the upper 2 BCD digits nonzero.
  - Overflow display: every digit shows a dash (seg 7'b0111111).
- Hex mode: the conversion FSM still runs for timing uniformity; DONE commits VALUE nibbles as digits, and overflow = 0.
- CTRL mode changes apply on the next commit, not immediately.
- Blanking (CTRL bit2): leading-zero digits above digit 0 are unlit (seg = 7'h7F). Digit 0 is always shown.
- Scan: a divider counts 0..SCAN_DIV-1; at terminal count the digit index increments modulo 8.
  - an = ~(1 << index), registered.
  - With enable = 0: an = 8'hFF and the divider holds at 0.
- Loads: read_data is a pure combinational function of endereco and register state; mem_read only gates the output to 0 when low.

## Timing
- Reset values:
  - VALUE = 0, CTRL = 3'b001, digits all 0, overflow = 0, busy = 0.
  - Scan index = 0, divider = 0, an = 8'hFE, seg = 7'b1000000 ('0').
- Store accepted at edge N: VALUE updates at N, busy = 1 from N.
- SHIFT occupies edges N+1..N+32; DONE commits at N+33 with busy = 0 after N+33.
- seg reflects new digits from edge N+34, once the registered seg/an pipeline has updated.
- Simultaneous mem_write and mem_read: the write takes effect, and read_data shows the pre-write value.
- Reset asserted mid-conversion: the FSM returns to IDLE and no commit occurs; the displayed digits revert to the reset values.
- Divider wrap: index 7 → 0.

## Test plan
- Reset, then hold 20 cycles -> an = 8'hFE, seg = 7'b1000000, busy = 0; a load of CTRL returns 32'h1.
- Word store 32'd12345678 to VALUE at edge N -> busy high through N+32, low after N+33; scanning shows digits 8,7,6,5,4,3,2,1 on an[0..7]; STATUS = 0.
- Store 32'd100_000_000 -> STATUS = 32'h2 after commit; all digits show 7'b0111111.
- Store CTRL = 3'b111, then VALUE = 32'h00DE_00AD -> hex digits D,A,0,0,E,D shown on an[0..5]; an[6] and an[7] positions blanked (seg 7'h7F).
- Byte store 8'h55 at BASE_ADDR+1 over VALUE = 32'h1122_3344 -> VALUE reads 32'h1122_5544. A half store at BASE_ADDR+1 is ignored.
- Store VALUE = 5 and, 10 cycles later, VALUE = 9 -> only 9 is committed, 33 cycles after the second store. Reset at cycle 5 of a new conversion -> no commit, busy = 0 next cycle.
